// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the CPU fetch and load/store channels.
// One transaction in flight at a time; ties alternate between channels.
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_W-1:0]     PC,
    input  logic                  Inst_Req_Valid,
    output logic                  Inst_Req_Ready,
    output logic [DATA_W-1:0]     Instruction,
    output logic                  Inst_Valid,
    input  logic                  Inst_Ready,

    input  logic [ADDR_W-1:0]     Address,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [DATA_W/8-1:0]   Write_strb,
    input  logic [DATA_W-1:0]     Write_data,
    output logic                  Mem_Req_Ack,
    output logic [DATA_W-1:0]     Read_data,
    output logic                  Read_data_Valid,
    input  logic                  Read_data_Ready,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W/8-1:0]   mem_req_wstrb,
    output logic [DATA_W-1:0]     mem_req_wdata,

    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_W-1:0]     mem_rsp_data,

    output logic [31:0]           inst_grant_cnt,
    output logic [31:0]           data_grant_cnt
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    state_t              state_p0;
    state_t              state_nxt;
    logic                owner_p0;
    logic                last_grant_p0;
    logic [31:0]         inst_cnt_p0;
    logic [31:0]         data_cnt_p0;
    logic [DATA_W-1:0]   rsp_buf_p0;

    logic [ADDR_W-1:0]   req_addr_p0;
    logic                req_wen_p0;
    logic [STRB_W-1:0]   req_wstrb_p0;
    logic [DATA_W-1:0]   req_wdata_p0;

    logic                inst_pend;
    logic                data_pend;
    logic                grant_inst;
    logic                grant_data;
    logic                owner_rdy;
    logic                in_issue;

    function automatic logic [31:0] cnt_inc(input logic [31:0] cnt);
        return cnt + 32'd1;
    endfunction

    assign inst_pend = Inst_Req_Valid;
    assign data_pend = MemWrite | MemRead;
    assign owner_rdy = owner_p0 ? Read_data_Ready : Inst_Ready;

    always_comb begin
        state_nxt  = state_p0;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        case (state_p0)
            IDLE: begin
                // On a tie the channel not served last time wins.
                if (!rst) begin
                    if (data_pend && (!inst_pend || !last_grant_p0)) begin
                        grant_data = 1'b1;
                    end else if (inst_pend) begin
                        grant_inst = 1'b1;
                    end
                end
                if (grant_inst || grant_data) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_nxt = req_wen_p0 ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    state_nxt = DELIVER;
                end
            end
            DELIVER: begin
                if (owner_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, counters and the response buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0      <= IDLE;
            owner_p0      <= 1'b0;
            last_grant_p0 <= 1'b0;
            inst_cnt_p0   <= '0;
            data_cnt_p0   <= '0;
            rsp_buf_p0    <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (grant_data) begin
                owner_p0      <= 1'b1;
                last_grant_p0 <= 1'b1;
                data_cnt_p0   <= cnt_inc(data_cnt_p0);
            end else if (grant_inst) begin
                owner_p0      <= 1'b0;
                last_grant_p0 <= 1'b0;
                inst_cnt_p0   <= cnt_inc(inst_cnt_p0);
            end
            if (state_p0 == WAIT_RSP && mem_rsp_valid) begin
                rsp_buf_p0 <= mem_rsp_data;
            end
        end
    end

    // Request payload; a simultaneous write and read is issued as a write
    always_ff @(posedge clk) begin
        if (grant_data) begin
            req_addr_p0  <= Address;
            req_wen_p0   <= MemWrite;
            req_wstrb_p0 <= Write_strb;
            req_wdata_p0 <= Write_data;
        end else if (grant_inst) begin
            req_addr_p0  <= PC;
            req_wen_p0   <= 1'b0;
            req_wstrb_p0 <= '0;
            req_wdata_p0 <= '0;
        end
    end

    assign in_issue = (state_p0 == ISSUE);

    assign Inst_Req_Ready  = grant_inst;
    assign Mem_Req_Ack     = grant_data;

    assign mem_req_valid   = in_issue;
    assign mem_req_wen     = in_issue ? req_wen_p0   : 1'b0;
    assign mem_req_addr    = in_issue ? req_addr_p0  : '0;
    assign mem_req_wstrb   = in_issue ? req_wstrb_p0 : '0;
    assign mem_req_wdata   = in_issue ? req_wdata_p0 : '0;
    assign mem_rsp_ready   = (state_p0 == WAIT_RSP);

    assign Inst_Valid      = (state_p0 == DELIVER) && !owner_p0;
    assign Read_data_Valid = (state_p0 == DELIVER) && owner_p0;
    assign Instruction     = rsp_buf_p0;
    assign Read_data       = rsp_buf_p0;

    assign inst_grant_cnt  = inst_cnt_p0;
    assign data_grant_cnt  = data_cnt_p0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: transaction-level reference model with per-cycle
// comparison, a simple memory responder, and directed scenarios.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [3:0]  Write_strb;
    logic [31:0] Write_data;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;

    int checks = 0;
    int failures = 0;
    bit model_on = 1'b0;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_strb(Write_strb), .Write_data(Write_data), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one outstanding transaction) ----------------
    bit          m_busy, m_issued, m_have_rsp, m_owner_data, m_last_data, m_wen;
    logic [31:0] m_addr, m_wdata, m_buf, m_icnt, m_dcnt;
    logic [3:0]  m_strb;

    function automatic void m_grant(output bit gi, output bit gd);
        bit ip;
        bit dp;
        ip = (Inst_Req_Valid === 1'b1);
        dp = (MemWrite === 1'b1) || (MemRead === 1'b1);
        gi = 1'b0;
        gd = 1'b0;
        if (rst !== 1'b1 && !m_busy) begin
            if (ip && dp) begin
                gd = !m_last_data;
                gi = m_last_data;
            end else begin
                gi = ip;
                gd = dp;
            end
        end
    endfunction

    always @(posedge clk) begin
        bit gi, gd;
        m_grant(gi, gd);
        if (rst === 1'b1) begin
            m_busy = 0; m_issued = 0; m_have_rsp = 0; m_last_data = 0;
            m_icnt = 0; m_dcnt = 0; m_buf = 0;
        end else if (!m_busy) begin
            if (gi || gd) begin
                m_busy = 1; m_issued = 0; m_have_rsp = 0;
                m_owner_data = gd; m_last_data = gd;
                if (gd) begin
                    m_wen = MemWrite; m_addr = Address; m_strb = Write_strb; m_wdata = Write_data;
                    m_dcnt = m_dcnt + 32'd1;
                end else begin
                    m_wen = 0; m_addr = PC;
                    m_icnt = m_icnt + 32'd1;
                end
            end
        end else if (!m_issued) begin
            if (mem_req_ready) begin
                if (m_wen) m_busy = 0;
                else m_issued = 1;
            end
        end else if (!m_have_rsp) begin
            if (mem_rsp_valid) begin
                m_buf = mem_rsp_data;
                m_have_rsp = 1;
            end
        end else if (m_owner_data ? Read_data_Ready : Inst_Ready) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        bit gi, gd, e_req, e_iv, e_rv;
        if (model_on) begin
            m_grant(gi, gd);
            e_req = m_busy && !m_issued;
            e_iv  = m_busy && m_have_rsp && !m_owner_data;
            e_rv  = m_busy && m_have_rsp && m_owner_data;
            chk("m_inst_req_ready", Inst_Req_Ready, gi);
            chk("m_mem_req_ack", Mem_Req_Ack, gd);
            chk("m_mem_req_valid", mem_req_valid, e_req);
            chk("m_mem_rsp_ready", mem_rsp_ready, m_busy && m_issued && !m_have_rsp);
            chk("m_inst_valid", Inst_Valid, e_iv);
            chk("m_read_data_valid", Read_data_Valid, e_rv);
            chk("m_inst_cnt", inst_grant_cnt, m_icnt);
            chk("m_data_cnt", data_grant_cnt, m_dcnt);
            if (e_req) begin
                chk("m_req_addr", mem_req_addr, m_addr);
                chk("m_req_wen", mem_req_wen, m_wen);
                if (m_wen) begin
                    chk("m_req_wstrb", mem_req_wstrb, m_strb);
                    chk("m_req_wdata", mem_req_wdata, m_wdata);
                end
            end
            if (e_iv) chk("m_instruction", Instruction, m_buf);
            if (e_rv) chk("m_read_data", Read_data, m_buf);
        end
    end

    // ---------------- memory responder ----------------
    logic [31:0] mem_arr [logic [31:0]];
    int          stall_left = 0;
    int          rsp_delay = 0;
    int          rsp_left = 0;
    bit          rsp_pend = 0;
    logic [31:0] rsp_addr;

    always begin
        bit s_hs, s_rhs, s_vld, s_wen, s_rst;
        logic [31:0] s_addr, s_wdata;
        @(negedge clk);
        s_hs = mem_req_valid && mem_req_ready;
        s_rhs = mem_rsp_valid && mem_rsp_ready;
        s_vld = mem_req_valid;
        s_wen = mem_req_wen;
        s_addr = mem_req_addr;
        s_wdata = mem_req_wdata;
        s_rst = rst;
        @(posedge clk);
        #1;
        if (s_rst) begin
            rsp_pend = 0;
            mem_rsp_valid = 0;
        end else begin
            if (s_rhs) mem_rsp_valid = 0;
            if (s_vld && !s_hs && stall_left > 0) stall_left--;
            if (s_hs) begin
                if (s_wen) mem_arr[s_addr] = s_wdata;
                else begin
                    rsp_pend = 1;
                    rsp_left = rsp_delay;
                    rsp_addr = s_addr;
                end
            end
            if (rsp_pend) begin
                if (rsp_left == 0) begin
                    mem_rsp_valid = 1;
                    mem_rsp_data = mem_arr.exists(rsp_addr) ? mem_arr[rsp_addr] : 32'h0;
                    rsp_pend = 0;
                end else begin
                    rsp_left--;
                end
            end
        end
        mem_req_ready = (stall_left == 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1; PC = 0; Inst_Req_Valid = 0; Inst_Ready = 1;
        Address = 0; MemWrite = 0; MemRead = 0; Write_strb = 0; Write_data = 0;
        Read_data_Ready = 1; mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = 0;
        mem_arr[32'h100] = 32'h0000_0013;
        mem_arr[32'h020] = 32'hDEAD_BEEF;
        mem_arr[32'h024] = 32'h1122_3344;
        steps(2);
        rst = 0;
        model_on = 1;
        @(negedge clk);
        chk("rst_inst_valid", Inst_Valid, 0);
        chk("rst_rd_valid", Read_data_Valid, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 0);
        chk("rst_req_wen", mem_req_wen, 0);
        chk("rst_req_wstrb", mem_req_wstrb, 0);
        chk("rst_req_wdata", mem_req_wdata, 0);
        chk("rst_rsp_ready", mem_rsp_ready, 0);
        chk("rst_instruction", Instruction, 0);
        chk("rst_read_data", Read_data, 0);
        chk("rst_inst_cnt", inst_grant_cnt, 0);
        chk("rst_data_cnt", data_grant_cnt, 0);

        // Fetch alone
        step(); PC = 32'h100; Inst_Req_Valid = 1;
        @(negedge clk); chk("fetch_grant", Inst_Req_Ready, 1);
        step(); Inst_Req_Valid = 0;
        @(negedge clk);
        chk("fetch_issue_valid", mem_req_valid, 1);
        chk("fetch_issue_addr", mem_req_addr, 32'h100);
        chk("fetch_issue_wen", mem_req_wen, 0);
        steps(2);
        @(negedge clk);
        chk("fetch_inst_valid", Inst_Valid, 1);
        chk("fetch_instruction", Instruction, 32'h13);
        chk("fetch_cnt", inst_grant_cnt, 1);
        step();
        @(negedge clk); chk("fetch_done", Inst_Valid, 0);

        // Store with downstream backpressure
        stall_left = 3;
        step(); Address = 32'h0C; MemWrite = 1; Write_strb = 4'hF; Write_data = 0;
        @(negedge clk); chk("store_ack", Mem_Req_Ack, 1);
        step(); MemWrite = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("store_hold_valid", mem_req_valid, 1);
            chk("store_hold_addr", mem_req_addr, 32'h0C);
            chk("store_hold_wen", mem_req_wen, 1);
            chk("store_hold_strb", mem_req_wstrb, 4'hF);
            step();
        end
        @(negedge clk);
        chk("store_idle_valid", mem_req_valid, 0);
        chk("store_no_rsp", mem_rsp_ready, 0);
        chk("store_no_beat", Read_data_Valid, 0);

        // Tie from reset: data, inst, then data again
        rst = 1; step(); rst = 0;
        Inst_Req_Valid = 1; PC = 32'h104; MemRead = 1; Address = 32'h20;
        @(negedge clk);
        chk("tie1_data", Mem_Req_Ack, 1);
        chk("tie1_inst_wait", Inst_Req_Ready, 0);
        step(); MemRead = 0;
        steps(2);
        @(negedge clk);
        chk("tie1_rd_valid", Read_data_Valid, 1);
        chk("tie1_rd_data", Read_data, 32'hDEADBEEF);
        chk("tie1_inst_blocked", Inst_Req_Ready, 0);
        step();
        @(negedge clk); chk("tie1_inst_next", Inst_Req_Ready, 1);
        step(); Inst_Req_Valid = 0;
        steps(3);
        MemRead = 1; Address = 32'h24; Inst_Req_Valid = 1; PC = 32'h108;
        @(negedge clk);
        chk("tie2_data", Mem_Req_Ack, 1);
        chk("tie2_inst_wait", Inst_Req_Ready, 0);
        step(); MemRead = 0;
        steps(3);
        @(negedge clk); chk("tie2_inst_next", Inst_Req_Ready, 1);
        step(); Inst_Req_Valid = 0;
        steps(3);

        // Load with upstream backpressure
        Read_data_Ready = 0; MemRead = 1; Address = 32'h20;
        @(negedge clk); chk("bp_ack", Mem_Req_Ack, 1);
        step(); MemRead = 0; Inst_Req_Valid = 1; PC = 32'h10C;
        steps(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", Read_data_Valid, 1);
            chk("bp_hold_data", Read_data, 32'hDEADBEEF);
            chk("bp_no_grant", Inst_Req_Ready, 0);
            step();
        end
        Read_data_Ready = 1;
        @(negedge clk);
        chk("bp_hs_valid", Read_data_Valid, 1);
        chk("bp_hs_no_grant", Inst_Req_Ready, 0);
        step();
        @(negedge clk);
        chk("bp_after_grant", Inst_Req_Ready, 1);
        chk("bp_after_valid", Read_data_Valid, 0);
        step(); Inst_Req_Valid = 0;
        steps(3);

        // Reset while waiting for a response
        rsp_delay = 4; MemRead = 1; Address = 32'h20;
        @(negedge clk); chk("rw_ack", Mem_Req_Ack, 1);
        step(); MemRead = 0;
        step();
        @(negedge clk); chk("rw_waiting", mem_rsp_ready, 1);
        step(); rst = 1;
        step(); rst = 0; rsp_delay = 0;
        @(negedge clk);
        chk("rw_rsp_ready", mem_rsp_ready, 0);
        chk("rw_req_valid", mem_req_valid, 0);
        chk("rw_rd_valid", Read_data_Valid, 0);
        chk("rw_inst_valid", Inst_Valid, 0);
        chk("rw_read_data", Read_data, 0);
        chk("rw_inst_cnt", inst_grant_cnt, 0);
        chk("rw_data_cnt", data_grant_cnt, 0);
        step(); MemRead = 1; Address = 32'h24; Inst_Req_Valid = 1; PC = 32'h110;
        @(negedge clk);
        chk("rw_tie_data", Mem_Req_Ack, 1);
        chk("rw_tie_inst_wait", Inst_Req_Ready, 0);
        step(); MemRead = 0;
        steps(3);
        @(negedge clk); chk("rw_inst_next", Inst_Req_Ready, 1);
        step(); Inst_Req_Valid = 0;
        steps(3);

        // Counter wrap; write+read together is issued as a write
        force dut.data_cnt_p0 = 32'hFFFF_FFFF;
        m_dcnt = 32'hFFFF_FFFF;
        #1;
        release dut.data_cnt_p0;
        @(negedge clk); chk("wrap_preset", data_grant_cnt, 32'hFFFFFFFF);
        step(); MemWrite = 1; MemRead = 1; Address = 32'h30; Write_strb = 4'h3; Write_data = 32'hCAFE;
        @(negedge clk); chk("wrap_ack", Mem_Req_Ack, 1);
        step(); MemWrite = 0; MemRead = 0;
        @(negedge clk);
        chk("wrap_cnt", data_grant_cnt, 0);
        chk("wrap_wen", mem_req_wen, 1);
        chk("wrap_wdata", mem_req_wdata, 32'hCAFE);
        step();
        @(negedge clk);
        chk("wrap_no_rsp", mem_rsp_ready, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
